// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file with hardware clear.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int unsigned MAX_WIDTH = 64;

  // Even parity: the returned bit makes the total count of ones even.
  // Callers zero-extend to MAX_WIDTH, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry once, writing zero, then idles for one cycle.
// Blocks port writes for the whole CLEAR and DONE window.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 20,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we_c,
  output logic [AW-1:0] clr_addr_c,
  output logic          wr_block_c
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state, state_d;
  logic [AW-1:0] ptr, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      clr_busy <= (state_d == CLEAR);
    end
  end

  // Next state and storage-side controls; clr_req is only honoured in IDLE.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    clr_we_c   = 1'b0;
    clr_addr_c = ptr;
    wr_block_c = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_we_c = 1'b1;
        if (ptr == LAST) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/param_regfile_clr.sv
// Parametrised register file: one write port, registered read port, flat image
// output and a hardware clear sequencer. Optional parity via REGFILE_PARITY_EN.
module param_regfile_clr
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 20,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   err,
  input  logic                   clr_req,
  output logic                   clr_busy,
`ifdef REGFILE_PARITY_EN
  output logic                   par_err,
`endif
  output logic [DEPTH*WIDTH-1:0] all_data
);

`ifdef REGFILE_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [SW-1:0] mem [DEPTH];

  logic          clr_we_c;
  logic [AW-1:0] clr_addr_c;
  logic          wr_block_c;
  logic          wr_in_range_c;
  logic          rd_in_range_c;
  logic          wr_commit_c;
  logic          err_c;
  logic [SW-1:0] wr_word_c;
  logic [SW-1:0] rd_word_c;

  regfile_clr_seq #(
    .DEPTH(DEPTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_we_c  (clr_we_c),
    .clr_addr_c(clr_addr_c),
    .wr_block_c(wr_block_c)
  );

  assign wr_in_range_c = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range_c = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_commit_c   = wr_en & wr_in_range_c & ~wr_block_c;
  assign err_c         = (wr_en & (~wr_in_range_c | wr_block_c)) | (rd_en & ~rd_in_range_c);
  assign rd_word_c     = rd_in_range_c ? mem[rd_addr] : '0;

`ifdef REGFILE_PARITY_EN
  assign wr_word_c = {even_parity(MAX_WIDTH'(wr_data)), wr_data};
`else
  assign wr_word_c = wr_data;
`endif

  // Storage; the sequencer and port writes never overlap because writes are blocked while clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we_c) begin
      mem[clr_addr_c] <= '0;
    end else if (wr_commit_c) begin
      mem[wr_addr] <= wr_word_c;
    end
  end

  // Read port samples pre-write contents, giving read-before-write on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      err      <= err_c;
      if (rd_en) rd_data <= rd_word_c[WIDTH-1:0];
    end
  end

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= rd_en & rd_in_range_c &
                 (even_parity(MAX_WIDTH'(rd_word_c[WIDTH-1:0])) != rd_word_c[WIDTH]);
    end
  end
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_img
    assign all_data[i*WIDTH +: WIDTH] = mem[i][WIDTH-1:0];
  end

endmodule
